encode_mul_pipe: RTL and testbench

Parametrised pipelined multiplier for the ADPCM encode datapath. It supersedes the fixed 15×10 unsigned DSP multiplier. It adds per-operand signedness, configurable pipeline depth, a valid bit that travels with the data, and an output post-processing stage (right shift, optional round-half-up, narrowing). It sits between the encoder's quantiser/predictor arithmetic and its consumers, and is stalled by the shared `ce`.

---
 rtl/encode_arith_pkg.sv | 16 +
 rtl/encode_mul_post.sv | 36 +++
 rtl/encode_mul_pipe.sv | 109 ++++++++++
 tb/tb_encode_mul_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/encode_arith_pkg.sv
// encode_arith_pkg: shared stage bounds, product-width and saturation helpers for the encode datapath
package encode_arith_pkg;
  localparam int MUL_STAGE_MIN = 3;
  localparam int MUL_STAGE_MAX = 8;
  localparam int SAT_VEC_W = 65;
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction
  // Range limit of a w-bit result, extended to SAT_VEC_W bits: signed picks min/max by neg, unsigned is all-ones
  function automatic logic [SAT_VEC_W-1:0] sat_limit(input logic neg, input int w, input logic sgn);
    logic [SAT_VEC_W-1:0] m;
    for (int i = 0; i < SAT_VEC_W; i++)
      m[i] = sgn ? (neg ? i >= w - 1 : i < w - 1) : i < w;
    return m;
  endfunction
endpackage

// File: rtl/encode_mul_post.sv
// encode_mul_post: combinational round / shift / narrow / overflow of a full-width product
// Ports: prod (PW-bit exact product) -> dout (W bits), ovf (narrowing lost magnitude)
// Build option: ENCODE_MUL_PIPE_SAT_EN selects saturating narrowing; otherwise truncate and ovf=0
module encode_mul_post import encode_arith_pkg::*; #(
  parameter int PW = 25,
  parameter int W = 25,
  parameter int SHIFT = 0,
  parameter int ROUND = 0,
  parameter bit P_S = 1'b0
) (
  input  logic [PW-1:0] prod,
  output logic [W-1:0]  dout,
  output logic          ovf
);
  localparam int RS = SHIFT > 0 ? SHIFT - 1 : 0;
  localparam logic [PW:0] RC = (ROUND != 0 && SHIFT > 0) ? (PW + 1)'(1) << RS : '0;
  logic [PW:0] sum, sh;
  logic signed [PW:0] sh_s;
  always_comb begin
    sum = (P_S ? {prod[PW-1], prod} : {1'b0, prod}) + RC;
    sh_s = $signed(sum) >>> SHIFT;
    sh = P_S ? sh_s : sum >> SHIFT;
  end
`ifdef ENCODE_MUL_PIPE_SAT_EN
  logic [PW:0] lo_ext;
  // In range exactly when the shifted value equals the extension of its own low W bits
  assign lo_ext = P_S ? {{(PW + 1 - W){sh[W-1]}}, sh[W-1:0]} : {{(PW + 1 - W){1'b0}}, sh[W-1:0]};
  assign ovf = sh != lo_ext;
  assign dout = ovf ? W'(sat_limit(sh[PW], W, P_S)) : sh[W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^sh[PW:W];
  assign dout = sh[W-1:0];
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/encode_mul_pipe.sv
// encode_mul_pipe: pipelined signed/unsigned multiplier with valid tracking and post-processing
// Ports: clk, reset (async active-low), ce (global hold), din0/din1/in_vld in; dout/out_vld/ovf out
// Build option: ENCODE_MUL_PIPE_SAT_EN selects saturating narrowing; otherwise truncate and ovf=0
module encode_mul_pipe import encode_arith_pkg::*; #(
  parameter int ID = 1,
  parameter int NUM_STAGE = 4,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 25,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0,
  parameter int SHIFT = 0,
  parameter int ROUND = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_vld,
  output logic                  ovf
);
  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
  localparam bit P_S = A_SIGNED != 0 || B_SIGNED != 0;
  localparam int ND = NUM_STAGE - MUL_STAGE_MIN;
  if (NUM_STAGE < MUL_STAGE_MIN || NUM_STAGE > MUL_STAGE_MAX) begin : g_bad_stage
    $error("encode_mul_pipe %0d: NUM_STAGE %0d outside legal range", ID, NUM_STAGE);
  end
  if (din0_WIDTH < 2 || din0_WIDTH > 32 || din1_WIDTH < 2 || din1_WIDTH > 32) begin : g_bad_din
    $error("encode_mul_pipe %0d: operand width outside 2..32", ID);
  end
  if (dout_WIDTH < 1 || dout_WIDTH > PW) begin : g_bad_dout
    $error("encode_mul_pipe %0d: dout_WIDTH %0d outside 1..%0d", ID, dout_WIDTH, PW);
  end
  if (SHIFT < 0 || SHIFT > PW - 1 || A_SIGNED < 0 || A_SIGNED > 1 || B_SIGNED < 0 || B_SIGNED > 1 ||
      ROUND < 0 || ROUND > 1) begin : g_bad_mode
    $error("encode_mul_pipe %0d: illegal SHIFT/ROUND/signedness setting", ID);
  end
  logic [din0_WIDTH-1:0] a_q, a_d;
  logic [din1_WIDTH-1:0] b_q, b_d;
  logic [PW-1:0] a_x, b_x, p_q, p_d, p_t;
  logic v1_q, v1_d, v2_q, v2_d, v_t, vld_q, vld_d, ovf_q, ovf_d, post_ovf;
  logic [dout_WIDTH-1:0] dout_q, dout_d, post_dout;
  // Extending both operands to PW bits keeps the low PW bits of the product exact for every signedness mix
  always_comb begin
    a_d = ce ? din0 : a_q;
    b_d = ce ? din1 : b_q;
    v1_d = ce ? in_vld : v1_q;
    a_x = {{(PW - din0_WIDTH){A_SIGNED != 0 && a_q[din0_WIDTH-1]}}, a_q};
    b_x = {{(PW - din1_WIDTH){B_SIGNED != 0 && b_q[din1_WIDTH-1]}}, b_q};
    p_d = ce ? a_x * b_x : p_q;
    v2_d = ce ? v1_q : v2_q;
    dout_d = ce ? post_dout : dout_q;
    ovf_d = ce ? post_ovf : ovf_q;
    vld_d = ce ? v_t : vld_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      v1_q <= 1'b0;
      p_q <= '0;
      v2_q <= 1'b0;
      dout_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v1_q <= v1_d;
      p_q <= p_d;
      v2_q <= v2_d;
      dout_q <= dout_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  if (ND > 0) begin : g_dly
    logic [ND-1:0][PW-1:0] dp_q, dp_d;
    logic [ND-1:0] dv_q, dv_d;
    // Shift toward the top; the truncating cast drops the oldest entry
    always_comb begin
      dp_d = ce ? (ND * PW)'({dp_q, p_q}) : dp_q;
      dv_d = ce ? ND'({dv_q, v2_q}) : dv_q;
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        dp_q <= '0;
        dv_q <= '0;
      end else begin
        dp_q <= dp_d;
        dv_q <= dv_d;
      end
    assign p_t = dp_q[ND-1];
    assign v_t = dv_q[ND-1];
  end else begin : g_nodly
    assign p_t = p_q;
    assign v_t = v2_q;
  end
  encode_mul_post #(
    .PW(PW), .W(dout_WIDTH), .SHIFT(SHIFT), .ROUND(ROUND), .P_S(P_S)
  ) u_post (
    .prod(p_t), .dout(post_dout), .ovf(post_ovf)
  );
  assign dout = dout_q;
  assign out_vld = vld_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_encode_mul_pipe.sv
// tb_encode_mul_pipe: scoreboard bench over four encode_mul_pipe configurations sharing clk/reset/ce
module tb_encode_mul_pipe;
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        o;
  } exp_t;
  localparam int NS [4] = '{4, 3, 8, 5};
  localparam int WD [4] = '{25, 16, 16, 16};
  localparam int SG [4] = '{0, 1, 1, 1};
  localparam int SH [4] = '{0, 15, 15, 4};
  localparam int RD [4] = '{0, 1, 0, 1};
  logic clk = 1'b0, reset = 1'b1, ce = 1'b0, in_vld = 1'b0;
  logic [14:0] din0_0 = '0;
  logic [9:0] din1_0 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [24:0] dout0;
  logic [15:0] dout1, dout2, dout3;
  logic [3:0] vld_v, ovf_v;
  logic [31:0] dq [4];
  logic [31:0] pd [4];
  logic pv [4], po [4];
  logic mon_ce, mon_rst;
  exp_t mon_e;
  exp_t sbq [4][$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always #5 clk = ~clk;
  encode_mul_pipe u0 (
    .clk(clk), .reset(reset), .ce(ce), .din0(din0_0), .din1(din1_0), .in_vld(in_vld),
    .dout(dout0), .out_vld(vld_v[0]), .ovf(ovf_v[0])
  );
  encode_mul_pipe #(
    .ID(2), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16),
    .A_SIGNED(1), .B_SIGNED(1), .SHIFT(15), .ROUND(1)
  ) u1 (
    .clk(clk), .reset(reset), .ce(ce), .din0(a16), .din1(b16), .in_vld(in_vld),
    .dout(dout1), .out_vld(vld_v[1]), .ovf(ovf_v[1])
  );
  encode_mul_pipe #(
    .ID(3), .NUM_STAGE(8), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16),
    .A_SIGNED(1), .B_SIGNED(1), .SHIFT(15), .ROUND(0)
  ) u2 (
    .clk(clk), .reset(reset), .ce(ce), .din0(a16), .din1(b16), .in_vld(in_vld),
    .dout(dout2), .out_vld(vld_v[2]), .ovf(ovf_v[2])
  );
  encode_mul_pipe #(
    .ID(4), .NUM_STAGE(5), .dout_WIDTH(16), .A_SIGNED(1), .SHIFT(4), .ROUND(1)
  ) u3 (
    .clk(clk), .reset(reset), .ce(ce), .din0(din0_0), .din1(din1_0), .in_vld(in_vld),
    .dout(dout3), .out_vld(vld_v[3]), .ovf(ovf_v[3])
  );
  assign dq[0] = 32'(dout0);
  assign dq[1] = 32'(dout1);
  assign dq[2] = 32'(dout2);
  assign dq[3] = 32'(dout3);
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d: got 0x%0h, want 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask
  // Reference: exact integer product, round, floor shift, then clamp or wrap to the output width
  function automatic exp_t model(input int k, input longint a, input longint b);
    longint p, lo, hi;
    exp_t e;
    p = a * b;
    if (RD[k] != 0 && SH[k] > 0) p = p + (longint'(1) <<< (SH[k] - 1));
    p = p >>> SH[k];
    lo = SG[k] != 0 ? -(longint'(1) <<< (WD[k] - 1)) : 64'sd0;
    hi = SG[k] != 0 ? (longint'(1) <<< (WD[k] - 1)) - 1 : (longint'(1) <<< WD[k]) - 1;
    e.due = cyc + NS[k];
    e.o = 1'b0;
`ifdef ENCODE_MUL_PIPE_SAT_EN
    if (p > hi) begin
      p = hi;
      e.o = 1'b1;
    end else if (p < lo) begin
      p = lo;
      e.o = 1'b1;
    end
`else
    if (lo > hi) e.o = 1'b1;
`endif
    e.d = 32'(p & ((longint'(1) <<< WD[k]) - 1));
    return e;
  endfunction
  task automatic push_all();
    longint a, b;
    for (int k = 0; k < 4; k++) begin
      if (k == 1 || k == 2) begin
        a = longint'($signed(a16));
        b = longint'($signed(b16));
      end else if (k == 3) begin
        a = longint'($signed(din0_0));
        b = longint'(din1_0);
      end else begin
        a = longint'(din0_0);
        b = longint'(din1_0);
      end
      sbq[k].push_back(model(k, a, b));
    end
  endtask
  task automatic drive(input logic c, input logic v, input logic [14:0] x0, input logic [9:0] x1,
                       input logic [15:0] y0, input logic [15:0] y1);
    @(negedge clk);
    ce = c;
    in_vld = v;
    din0_0 = x0;
    din1_0 = x1;
    a16 = y0;
    b16 = y1;
    if (c && v && reset) push_all();
  endtask
  function automatic logic [15:0] pick16();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 16'h8000 : r == 1 ? 16'h7fff : 16'($urandom);
  endfunction
  function automatic logic [14:0] pick15();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 15'h4000 : r == 1 ? 15'h7fff : 15'($urandom);
  endfunction
  task automatic drive_rand(input logic c, input logic v);
    drive(c, v, pick15(), 10'($urandom), pick16(), pick16());
  endtask
  always @(posedge clk) begin
    mon_ce = ce;
    mon_rst = reset;
    #1;
    if (mon_ce && mon_rst) cyc++;
    for (int k = 0; k < 4; k++) begin
      if (!mon_rst) begin
        chk("rst_vld", k, 32'(vld_v[k]), 32'd0);
        chk("rst_dout", k, dq[k], 32'd0);
        chk("rst_ovf", k, 32'(ovf_v[k]), 32'd0);
      end else if (!mon_ce) begin
        chk("hold_vld", k, 32'(vld_v[k]), 32'(pv[k]));
        chk("hold_dout", k, dq[k], pd[k]);
        chk("hold_ovf", k, 32'(ovf_v[k]), 32'(po[k]));
      end else if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
        mon_e = sbq[k].pop_front();
        chk("out_vld", k, 32'(vld_v[k]), 32'd1);
        chk("dout", k, dq[k], mon_e.d);
        chk("ovf", k, 32'(ovf_v[k]), 32'(mon_e.o));
      end else begin
        chk("idle_vld", k, 32'(vld_v[k]), 32'd0);
      end
      pd[k] = dq[k];
      pv[k] = vld_v[k];
      po[k] = ovf_v[k];
    end
  end
  initial begin
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("por_vld", k, 32'(vld_v[k]), 32'd0);
      chk("por_dout", k, dq[k], 32'd0);
      chk("por_ovf", k, 32'(ovf_v[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 15'd32767, 10'd1023, 16'd3, 16'd16384);
    drive(1'b1, 1'b1, 15'h4000, 10'd1023, 16'h8000, 16'h8000);
    drive(1'b1, 1'b1, 15'h4000, 10'd0, 16'h8000, 16'h7fff);
    for (int i = 0; i < 13; i++) drive_rand(!(i >= 5 && i < 8), 1'b1);
    repeat (10) drive_rand(1'b1, 1'b0);
    for (int i = 0; i < 150; i++) drive_rand($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
    repeat (10) drive_rand(1'b1, 1'b0);
    repeat (3) drive_rand(1'b1, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) sbq[k].delete();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("async_vld", k, 32'(vld_v[k]), 32'd0);
      chk("async_dout", k, dq[k], 32'd0);
      chk("async_ovf", k, 32'(ovf_v[k]), 32'd0);
    end
    repeat (2) drive_rand(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) drive_rand(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive_rand($urandom_range(0, 9) < 8, 1'b1);
    repeat (12) drive_rand(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) chk("drain", k, 32'(sbq[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
